// File: rtl/dma_block_copy.sv
// Block-copy DMA controller for the 6502 system bus.
// The CPU programs SRC/DST/LEN through an 8-byte register window and then
// writes START. The controller halts the CPU, owns the bus for two cycles
// per byte (read then write), hands the bus back and reports done.
module dma_block_copy (
  input  logic        clk,
  input  logic        reset,
  input  logic        chip_en,
  input  logic [2:0]  register_select,
  input  logic        READ_write,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        cpu_halt,
  output logic        bus_grant,
  output logic [15:0] dma_address,
  output logic [7:0]  dma_data_out,
  output logic        dma_write,
  input  logic [7:0]  dma_data_in,
  output logic        irq
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HANDOVER = 3'd1,
    S_READ     = 3'd2,
    S_WRITE    = 3'd3,
    S_RELEASE  = 3'd4
  } state_t;

  state_t      state, next_state;
  logic [15:0] src, dst, len;
  logic [7:0]  byte_buf;
  logic        done, irq_en;

  logic        busy;
  logic        reg_wr;
  logic        ctrl_wr;
  logic        start;
  logic        len_zero;
  logic [15:0] len_next;

  // Register writes are locked out for the whole transfer, so the working
  // copies of SRC/DST/LEN can only change through the copy itself.
  assign busy     = (state != S_IDLE);
  assign reg_wr   = chip_en & READ_write & ~busy;
  assign ctrl_wr  = reg_wr & (register_select == 3'd6);
  assign start    = ctrl_wr & data_in[0];
  assign len_zero = (len == 16'd0);
  assign len_next = len - 16'd1;
  assign irq      = done & irq_en;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic: one handover cycle, read/write per byte, one release cycle.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (start && !len_zero) next_state = S_HANDOVER;
      S_HANDOVER: next_state = S_READ;
      S_READ:     next_state = S_WRITE;
      S_WRITE:    next_state = (len_next == 16'd0) ? S_RELEASE : S_READ;
      S_RELEASE:  next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // Bus outputs decoded purely from registered state so they cannot glitch.
  always_comb begin
    cpu_halt     = busy;
    bus_grant    = 1'b0;
    dma_write    = 1'b0;
    dma_address  = 16'h0000;
    dma_data_out = 8'h00;
    case (state)
      S_READ: begin
        bus_grant   = 1'b1;
        dma_address = src;
      end
      S_WRITE: begin
        bus_grant    = 1'b1;
        dma_write    = 1'b1;
        dma_address  = dst;
        dma_data_out = byte_buf;
      end
      default: ;
    endcase
  end

  // Address/length registers: CPU writes while idle, post-increment in WRITE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src      <= 16'h0000;
      dst      <= 16'h0000;
      len      <= 16'h0000;
      byte_buf <= 8'h00;
    end else begin
      if (reg_wr) begin
        case (register_select)
          3'd0: src[7:0]  <= data_in;
          3'd1: src[15:8] <= data_in;
          3'd2: dst[7:0]  <= data_in;
          3'd3: dst[15:8] <= data_in;
          3'd4: len[7:0]  <= data_in;
          3'd5: len[15:8] <= data_in;
          default: ;
        endcase
      end
      if (state == S_READ) byte_buf <= dma_data_in;
      if (state == S_WRITE) begin
        src <= src + 16'd1;
        dst <= dst + 16'd1;
        len <= len_next;
      end
    end
  end

  // Completion and interrupt enable; START takes priority over CLR_DONE,
  // and a zero-length START completes immediately without touching the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done   <= 1'b0;
      irq_en <= 1'b0;
    end else if (ctrl_wr) begin
      irq_en <= data_in[1];
      if (data_in[0])      done <= len_zero;
      else if (data_in[2]) done <= 1'b0;
    end else if (state == S_RELEASE) begin
      done <= 1'b1;
    end
  end

  // Combinational register read-back; live working values while busy.
  always_comb begin
    data_out = 8'h00;
    if (chip_en && !READ_write) begin
      case (register_select)
        3'd0: data_out = src[7:0];
        3'd1: data_out = src[15:8];
        3'd2: data_out = dst[7:0];
        3'd3: data_out = dst[15:8];
        3'd4: data_out = len[7:0];
        3'd5: data_out = len[15:8];
        3'd6: data_out = {5'b00000, irq_en, done, busy};
        default: data_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_block_copy.sv
// Directed bench for dma_block_copy with a byte-wide system memory model
// and an ordered queue of expected bus cycles.
module tb_dma_block_copy;

  logic        clk;
  logic        reset;
  logic        chip_en;
  logic [2:0]  register_select;
  logic        READ_write;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        cpu_halt;
  logic        bus_grant;
  logic [15:0] dma_address;
  logic [7:0]  dma_data_out;
  logic        dma_write;
  logic [7:0]  dma_data_in;
  logic        irq;

  logic [7:0] mem [0:65535];

  typedef struct {
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
  } ev_t;
  ev_t evq[$];

  int total = 0;
  int bad   = 0;

  dma_block_copy dut (
    .clk             (clk),
    .reset           (reset),
    .chip_en         (chip_en),
    .register_select (register_select),
    .READ_write      (READ_write),
    .data_in         (data_in),
    .data_out        (data_out),
    .cpu_halt        (cpu_halt),
    .bus_grant       (bus_grant),
    .dma_address     (dma_address),
    .dma_data_out    (dma_data_out),
    .dma_write       (dma_write),
    .dma_data_in     (dma_data_in),
    .irq             (irq)
  );

  assign dma_data_in = mem[dma_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    chip_en = 1'b1; READ_write = 1'b1; register_select = a; data_in = d;
    @(negedge clk);
    chip_en = 1'b0; READ_write = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] d;
    chip_en = 1'b1; READ_write = 1'b0; register_select = a;
    #1;
    d = data_out;
    chip_en = 1'b0;
    chk(tag, {8'h00, d}, {8'h00, exp});
  endtask

  task automatic prog(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    wr(3'd0, s[7:0]); wr(3'd1, s[15:8]);
    wr(3'd2, d[7:0]); wr(3'd3, d[15:8]);
    wr(3'd4, n[7:0]); wr(3'd5, n[15:8]);
  endtask

  task automatic push_copy(input logic [15:0] s, input logic [15:0] d, input int n);
    for (int k = 0; k < n; k++) begin
      evq.push_back('{1'b0, 16'(s + 16'(k)), 8'h00});
      evq.push_back('{1'b1, 16'(d + 16'(k)), mem[16'(s + 16'(k))]});
    end
  endtask

  // Called at the negedge right after the START edge; follows the transfer
  // until the halt drops, checking each bus cycle against the queue.
  task automatic run_xfer(input bit poke, output int halts);
    ev_t e;
    int  n;
    halts = 0;
    n = 0;
    while (cpu_halt && n < 200) begin
      halts++;
      if (poke && n == 1) begin
        chip_en = 1'b1; READ_write = 1'b1; register_select = 3'd0; data_in = 8'h55;
      end
      if (poke && n == 2) begin
        chip_en = 1'b0; READ_write = 1'b0;
      end
      if (bus_grant) begin
        if (evq.size() == 0) begin
          chk("extra_bus_cycle", 16'(evq.size()), 16'd1);
        end else begin
          e = evq.pop_front();
          chk("bus_dir", {15'd0, dma_write}, {15'd0, e.wr});
          chk("bus_addr", dma_address, e.a);
          if (e.wr) begin
            chk("bus_wdata", {8'h00, dma_data_out}, {8'h00, e.d});
            mem[dma_address] = dma_data_out;
          end
        end
      end else begin
        chk("dma_write_no_grant", {15'd0, dma_write}, 16'd0);
      end
      n++;
      @(negedge clk);
    end
    chip_en = 1'b0; READ_write = 1'b0;
    chk("xfer_finished", {15'd0, cpu_halt}, 16'd0);
    chk("events_left", 16'(evq.size()), 16'd0);
    evq.delete();
  endtask

  initial begin
    int halts;
    int nw;
    int n;

    reset = 1'b0; chip_en = 1'b0; READ_write = 1'b0;
    register_select = 3'd0; data_in = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_halt", {15'd0, cpu_halt}, 16'd0);
    chk("rst_grant", {15'd0, bus_grant}, 16'd0);
    chk("rst_dma_write", {15'd0, dma_write}, 16'd0);
    chk("rst_dma_addr", dma_address, 16'h0000);
    chk("rst_dma_data", {8'h00, dma_data_out}, 16'h0000);
    chk("rst_irq", {15'd0, irq}, 16'd0);
    chk("rst_data_out", {8'h00, data_out}, 16'h0000);
    chk_reg("rst_status", 3'd6, 8'h00);
    chk_reg("rst_len_l", 3'd4, 8'h00);

    // Basic 3-byte copy
    mem[16'h0010] = 8'hAA; mem[16'h0011] = 8'hBB; mem[16'h0012] = 8'hCC;
    prog(16'h0010, 16'h0100, 16'd3);
    push_copy(16'h0010, 16'h0100, 3);
    wr(3'd6, 8'h01);
    run_xfer(1'b0, halts);
    chk("copy_halt_cycles", 16'(halts), 16'd8);
    chk("copy_mem100", {8'h00, mem[16'h0100]}, 16'h00AA);
    chk("copy_mem101", {8'h00, mem[16'h0101]}, 16'h00BB);
    chk("copy_mem102", {8'h00, mem[16'h0102]}, 16'h00CC);
    chk_reg("copy_status", 3'd6, 8'h02);
    chk_reg("copy_src_l", 3'd0, 8'h13);
    chk_reg("copy_src_h", 3'd1, 8'h00);
    chk_reg("copy_dst_l", 3'd2, 8'h03);
    chk_reg("copy_dst_h", 3'd3, 8'h01);
    chk_reg("copy_len_l", 3'd4, 8'h00);
    chk_reg("copy_len_h", 3'd5, 8'h00);

    // Register reads are suppressed during a CPU write cycle
    chip_en = 1'b1; READ_write = 1'b1; register_select = 3'd6;
    #1;
    chk("data_out_on_write", {8'h00, data_out}, 16'h0000);
    chip_en = 1'b0; READ_write = 1'b0;

    // Zero-length START completes immediately without touching the bus
    wr(3'd6, 8'h04);
    chk_reg("clr_done_status", 3'd6, 8'h00);
    wr(3'd6, 8'h01);
    chk_reg("len0_status", 3'd6, 8'h02);
    for (int i = 0; i < 4; i++) begin
      chk("len0_halt", {15'd0, cpu_halt}, 16'd0);
      chk("len0_grant", {15'd0, bus_grant}, 16'd0);
      @(negedge clk);
    end

    // 16-bit address wrap on the source, carry into DST_H on the destination
    mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'hA5;
    prog(16'hFFFF, 16'h07FF, 16'd2);
    push_copy(16'hFFFF, 16'h07FF, 2);
    wr(3'd6, 8'h01);
    run_xfer(1'b0, halts);
    chk("wrap_halt_cycles", 16'(halts), 16'd6);
    chk("wrap_mem7ff", {8'h00, mem[16'h07FF]}, 16'h005A);
    chk("wrap_mem800", {8'h00, mem[16'h0800]}, 16'h00A5);
    chk_reg("wrap_src_l", 3'd0, 8'h01);
    chk_reg("wrap_src_h", 3'd1, 8'h00);

    // Interrupt follows done while enabled
    wr(3'd6, 8'h04);
    chk("irq_cleared", {15'd0, irq}, 16'd0);
    mem[16'h0020] = 8'h77;
    prog(16'h0020, 16'h0030, 16'd1);
    push_copy(16'h0020, 16'h0030, 1);
    wr(3'd6, 8'h03);
    chk("irq_during", {15'd0, irq}, 16'd0);
    run_xfer(1'b0, halts);
    chk("irq_halt_cycles", 16'(halts), 16'd4);
    chk("irq_after_done", {15'd0, irq}, 16'd1);
    chk_reg("irq_status", 3'd6, 8'h06);
    wr(3'd6, 8'h02);
    chk("irq_kept", {15'd0, irq}, 16'd1);
    wr(3'd6, 8'h04);
    chk("irq_dropped", {15'd0, irq}, 16'd0);
    chk_reg("irq_clr_status", 3'd6, 8'h00);

    // A register write while busy is ignored
    mem[16'h0040] = 8'h11; mem[16'h0041] = 8'h22;
    prog(16'h0040, 16'h0050, 16'd2);
    push_copy(16'h0040, 16'h0050, 2);
    wr(3'd6, 8'h01);
    run_xfer(1'b1, halts);
    chk("busy_wr_halt_cycles", 16'(halts), 16'd6);
    chk_reg("busy_wr_src_l", 3'd0, 8'h42);
    chk_reg("busy_wr_src_h", 3'd1, 8'h00);

    // Asynchronous reset during the WRITE of the third byte of five
    prog(16'h0060, 16'h0070, 16'd5);
    wr(3'd6, 8'h01);
    nw = 0;
    n = 0;
    while (n < 40) begin
      if (bus_grant && dma_write) begin
        nw++;
        if (nw == 3) break;
      end
      @(negedge clk);
      n++;
    end
    chk("abort_reached_write", 16'(nw), 16'd3);
    reset = 1'b0;
    #1;
    chk("abort_halt", {15'd0, cpu_halt}, 16'd0);
    chk("abort_grant", {15'd0, bus_grant}, 16'd0);
    chk("abort_dma_write", {15'd0, dma_write}, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 8; r++) chk_reg("abort_reg", 3'(r), 8'h00);
    chk("abort_irq", {15'd0, irq}, 16'd0);
    chk("abort_halt_after", {15'd0, cpu_halt}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
